systolic_drain: RTL and testbench

Output-side writer for the systolic MAC array: it consumes the staggered per-row result streams (`D`, `valid_D`) that the array drains after each tile and turns them into bank-wise write transactions into the output matrix memory (m2). m2 is organised as N1 banks, one per array row, with depth (M*M)/N1, mirroring the A-side read organisation. The block tracks tile position per row, generates write addresses, flags completion of the full M x M result, and detects surplus data.

---
 rtl/systolic_drain.sv | 115 +++++++++++
 tb/tb_systolic_drain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// systolic_drain: converts the staggered per-row drain streams of the systolic
// MAC array into bank-wise write transactions for the output matrix memory.
// Each row is tracked independently because the rows are skewed in time.
module systolic_drain #(
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned N1      = 4,
  parameter int unsigned N2      = 4,
  parameter int unsigned M       = 8,
  localparam int unsigned DEPTH  = (M * M) / N1,
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic [N1-1:0][D_W_ACC-1:0]      D,
  input  logic [N1-1:0]                   valid_D,
  output logic [N1-1:0]                   wr_en,
  output logic [N1-1:0][AW-1:0]           wr_addr,
  output logic [N1-1:0][D_W_ACC-1:0]      wr_data,
  output logic                            done,
  output logic                            overflow
);

  localparam int unsigned CBN = M / N2;
  localparam int unsigned RBN = M / N1;
  localparam int unsigned KW  = (N2 > 1)  ? $clog2(N2)  : 1;
  localparam int unsigned CBW = (CBN > 1) ? $clog2(CBN) : 1;
  localparam int unsigned RAW = (RBN > 1) ? $clog2(RBN) : 1;

  logic [N1-1:0][KW-1:0]  k_q,  k_nxt;
  logic [N1-1:0][CBW-1:0] cb_q, cb_nxt;
  logic [N1-1:0][RAW-1:0] ra_q, ra_nxt;
  logic [N1-1:0]          fin_q, fin_nxt;
  logic [N1-1:0]          accept_c;
  logic [N1-1:0][AW-1:0]  addr_c;
  logic                   ovf_hit_c;

  // Per-row address generation and tile-position counter advance
  always_comb begin
    k_nxt     = k_q;
    cb_nxt    = cb_q;
    ra_nxt    = ra_q;
    fin_nxt   = fin_q;
    accept_c  = '0;
    addr_c    = '0;
    ovf_hit_c = 1'b0;
    for (int i = 0; i < int'(N1); i++) begin
      // Rightmost PE drains first, so beat k lands on column N2-1-k of the block
      addr_c[i] = AW'(32'(ra_q[i]) * M + 32'(cb_q[i]) * N2 + (N2 - 1) - 32'(k_q[i]));
      if (valid_D[i]) begin
        if (fin_q[i]) begin
          ovf_hit_c = 1'b1;
        end else begin
          accept_c[i] = 1'b1;
          if (k_q[i] == KW'(N2 - 1)) begin
            k_nxt[i] = '0;
            if (cb_q[i] == CBW'(CBN - 1)) begin
              cb_nxt[i] = '0;
              if (ra_q[i] == RAW'(RBN - 1)) begin
                // Final beat of the matrix: park the counters and mark the row done
                cb_nxt[i]  = cb_q[i];
                k_nxt[i]   = k_q[i];
                fin_nxt[i] = 1'b1;
              end else begin
                ra_nxt[i] = ra_q[i] + RAW'(1);
              end
            end else begin
              cb_nxt[i] = cb_q[i] + CBW'(1);
            end
          end else begin
            k_nxt[i] = k_q[i] + KW'(1);
          end
        end
      end
    end
  end

  // Counter/flag state and registered write outputs; clear beats any valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      cb_q     <= '0;
      ra_q     <= '0;
      fin_q    <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      k_q      <= '0;
      cb_q     <= '0;
      ra_q     <= '0;
      fin_q    <= '0;
      wr_en    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      k_q      <= k_nxt;
      cb_q     <= cb_nxt;
      ra_q     <= ra_nxt;
      fin_q    <= fin_nxt;
      wr_en    <= accept_c;
      done     <= &fin_q;
      overflow <= overflow | ovf_hit_c;
      for (int i = 0; i < int'(N1); i++) begin
        if (accept_c[i]) begin
          wr_addr[i] <= addr_c[i];
          wr_data[i] <= D[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with default parameters (N1=N2=4, M=8).
module tb_systolic_drain;

  localparam int unsigned DW = 16;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 4;
  localparam int unsigned M  = 8;
  localparam int unsigned AW = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    clear;
  logic [N1-1:0][DW-1:0]   d;
  logic [N1-1:0]           valid_d;
  logic [N1-1:0]           wr_en;
  logic [N1-1:0][AW-1:0]   wr_addr;
  logic [N1-1:0][DW-1:0]   wr_data;
  logic                    done;
  logic                    overflow;

  int checks = 0;
  int errors = 0;

  systolic_drain #(.D_W_ACC(DW), .N1(N1), .N2(N2), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .D(d), .valid_D(valid_d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int j;
    rst_n   = 1'b0;
    clear   = 1'b0;
    valid_d = '0;
    d       = '0;
    #2;
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_wr_data", 32'(wr_data), 0);
    check("reset_done", 32'(done), 0);
    check("reset_overflow", 32'(overflow), 0);
    #10 rst_n = 1'b1;
    tick();

    // Single tile on row 0: addresses 3,2,1,0
    for (int k = 0; k < 4; k++) begin
      valid_d = 4'b0001;
      d[0]    = 16'(10 + k);
      tick();
      check($sformatf("t1_wr_en_%0d", k), 32'(wr_en), 1);
      check($sformatf("t1_addr_%0d", k), 32'(wr_addr[0]), 32'(3 - k));
      check($sformatf("t1_data_%0d", k), 32'(wr_data[0]), 32'(10 + k));
    end
    valid_d = '0;
    tick();
    check("t1_idle_wr_en", 32'(wr_en), 0);
    check("t1_hold_addr", 32'(wr_addr[0]), 0);
    check("t1_hold_data", 32'(wr_data[0]), 13);

    // Full matrix with rows skewed by their index
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 19; c++) begin
      valid_d = '0;
      for (int i = 0; i < 4; i++) begin
        j = c - i;
        if (j >= 0 && j < 16) begin
          valid_d[i] = 1'b1;
          d[i]       = 16'(i * 100 + j);
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        j = c - i;
        if (j >= 0 && j < 16) begin
          check($sformatf("full_en_c%0d_r%0d", c, i), 32'(wr_en[i]), 1);
          check($sformatf("full_addr_c%0d_r%0d", c, i), 32'(wr_addr[i]),
                32'((j / 4) * 4 + 3 - (j % 4)));
          check($sformatf("full_data_c%0d_r%0d", c, i), 32'(wr_data[i]), 32'(i * 100 + j));
        end else begin
          check($sformatf("full_en_c%0d_r%0d", c, i), 32'(wr_en[i]), 0);
        end
      end
      check($sformatf("full_done_c%0d", c), 32'(done), 0);
    end
    check("full_last_addr_r3", 32'(wr_addr[3]), 12);
    valid_d = '0;
    tick();
    check("full_done_rise", 32'(done), 1);
    check("full_idle_en", 32'(wr_en), 0);
    check("full_no_overflow", 32'(overflow), 0);

    // Overflow: extra beat on a finished row
    valid_d = 4'b0010;
    d[1]    = 16'd999;
    tick();
    check("ovf_no_write", 32'(wr_en), 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_done_kept", 32'(done), 1);
    check("ovf_data_held", 32'(wr_data[1]), 115);
    valid_d = '0;
    tick();
    check("ovf_sticky", 32'(overflow), 1);

    // Gapped burst on row 2 after clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_done", 32'(done), 0);
    check("clr_overflow", 32'(overflow), 0);
    check("clr_wr_en", 32'(wr_en), 0);
    begin
      logic [5:0] pat;
      int exp_addr;
      pat      = 6'b101101;
      exp_addr = 3;
      for (int s = 0; s < 6; s++) begin
        valid_d    = '0;
        valid_d[2] = pat[5 - s];
        d[2]       = 16'(20 + s);
        tick();
        if (pat[5 - s]) begin
          check($sformatf("gap_en_%0d", s), 32'(wr_en), 32'(4'b0100));
          check($sformatf("gap_addr_%0d", s), 32'(wr_addr[2]), 32'(exp_addr));
          check($sformatf("gap_data_%0d", s), 32'(wr_data[2]), 32'(20 + s));
          exp_addr--;
        end else begin
          check($sformatf("gap_en_%0d", s), 32'(wr_en), 0);
        end
      end
    end

    // Clear colliding with a valid beat mid tile 1
    clear   = 1'b1;
    valid_d = '0;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_d = 4'b0001;
      d[0]    = 16'(40 + k);
      tick();
    end
    check("coll_pre_addr", 32'(wr_addr[0]), 7);
    clear   = 1'b1;
    valid_d = 4'b0001;
    d[0]    = 16'd55;
    tick();
    clear = 1'b0;
    check("coll_no_write", 32'(wr_en), 0);
    check("coll_done", 32'(done), 0);
    check("coll_overflow", 32'(overflow), 0);
    check("coll_data_held", 32'(wr_data[0]), 44);
    valid_d = 4'b0001;
    d[0]    = 16'd66;
    tick();
    check("coll_next_en", 32'(wr_en), 1);
    check("coll_next_addr", 32'(wr_addr[0]), 3);
    check("coll_next_data", 32'(wr_data[0]), 66);

    // Asynchronous reset between edges, mid burst
    valid_d = 4'b0001;
    d[0]    = 16'd67;
    tick();
    check("ar_pre_addr", 32'(wr_addr[0]), 2);
    valid_d = '0;
    #3 rst_n = 1'b0;
    #1;
    check("ar_wr_en", 32'(wr_en), 0);
    check("ar_wr_addr", 32'(wr_addr), 0);
    check("ar_wr_data", 32'(wr_data), 0);
    check("ar_done", 32'(done), 0);
    check("ar_overflow", 32'(overflow), 0);
    #2 rst_n = 1'b1;
    valid_d = 4'b0001;
    d[0]    = 16'd77;
    tick();
    check("ar_next_en", 32'(wr_en), 1);
    check("ar_next_addr", 32'(wr_addr[0]), 3);
    check("ar_next_data", 32'(wr_data[0]), 77);
    valid_d = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
